dram_port_arbiter: RTL and testbench



---
 rtl/dram_port_arbiter_pkg.sv | 26 ++
 rtl/dram_port_arbiter_if.sv | 52 +++++
 rtl/dram_port_arbiter_arb_timeout_counter.sv | 44 ++++
 rtl/dram_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter_pkg
//   Shared definitions for the DRAM port arbiter and its helper counter:
//   arbiter state encoding, the fixed instruction-fetch access control,
//   default timing limits and a counter-width helper.
// ---------------------------------------------------------------------------
package dram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } arb_state_t;

   // Instruction fetches are always doubleword reads.
   localparam logic [2:0] IF_FETCH_CTRL = 3'b011;

   localparam int DEFAULT_TIMEOUT   = 255;
   localparam int DEFAULT_LS_STREAK = 4;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter_if
//   Bundles the IF requester, LS requester and DRAM port signals.
//   master : arbiter side (drives acks, read data, stalls, DRAM request).
//   slave  : environment side (requesters and the DRAM device).
// ---------------------------------------------------------------------------
interface dram_port_arbiter_if #(
   parameter int DRAM_AW = 64
) ();

   // instruction-fetch requester
   logic               if_req;
   logic [DRAM_AW-1:0] if_addr;
   logic               if_ack;
   logic [63:0]        if_rdata;
   logic               stall_if;

   // load/store requester
   logic               ls_req;
   logic [DRAM_AW-1:0] ls_addr;
   logic [63:0]        ls_din;
   logic [2:0]         ls_rd_ctrl;
   logic [2:0]         ls_wr_ctrl;
   logic               ls_ack;
   logic [63:0]        ls_rdata;
   logic               stall_ls;

   // DRAM port
   logic               dram_req;
   logic [DRAM_AW-1:0] dram_addr;
   logic [63:0]        dram_din;
   logic [2:0]         dram_rd_ctrl;
   logic [2:0]         dram_wr_ctrl;
   logic               dram_ack;
   logic [63:0]        dram_rdata;
   logic               timeout_err;

   modport master (
      input  if_req, if_addr, ls_req, ls_addr, ls_din, ls_rd_ctrl, ls_wr_ctrl,
             dram_ack, dram_rdata,
      output if_ack, if_rdata, stall_if, ls_ack, ls_rdata, stall_ls,
             dram_req, dram_addr, dram_din, dram_rd_ctrl, dram_wr_ctrl, timeout_err
   );

   modport slave (
      output if_req, if_addr, ls_req, ls_addr, ls_din, ls_rd_ctrl, ls_wr_ctrl,
             dram_ack, dram_rdata,
      input  if_ack, if_rdata, stall_if, ls_ack, ls_rdata, stall_ls,
             dram_req, dram_addr, dram_din, dram_rd_ctrl, dram_wr_ctrl, timeout_err
   );

endinterface

// File: rtl/dram_port_arbiter_arb_timeout_counter.sv
// ---------------------------------------------------------------------------
// arb_timeout_counter
//   Load/clear/increment counter with an expiry flag, saturating at LIMIT.
//   Ports:
//     clk        clock
//     reset      synchronous, active-low
//     i_load     load i_load_val (start of a transaction)
//     i_load_val value to load
//     i_clr      clear to zero (has priority over load)
//     i_inc      count one waiting cycle
//     o_expired  count has reached LIMIT
// ---------------------------------------------------------------------------
module arb_timeout_counter
   import dram_port_arbiter_pkg::*;
#(
   parameter int LIMIT = DEFAULT_TIMEOUT,
   parameter int W     = cnt_width(LIMIT)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic         o_expired
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_inc && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == W'(LIMIT));

endmodule

// File: rtl/dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter
//   Shares one DRAM port between the instruction-fetch (IF) and load/store
//   (LS) requesters. One req/ack transaction at a time; completion is a
//   one-cycle ack with registered read data. LS normally wins, but IF wins
//   once LS has taken LS_STREAK consecutive grants while IF was waiting.
//   A transaction with no dram_ack for TIMEOUT+1 busy cycles is aborted with
//   a timeout_err pulse and zero read data.
//   Ports:
//     clk    clock
//     reset  synchronous, active-low
//     bus    dram_port_arbiter_if.master (requesters + DRAM port)
// ---------------------------------------------------------------------------
module dram_port_arbiter
   import dram_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT   = DEFAULT_TIMEOUT,
   parameter int LS_STREAK = DEFAULT_LS_STREAK,
   parameter int DRAM_AW   = 64
) (
   input  logic                clk,
   input  logic                reset,
   dram_port_arbiter_if.master bus
);

   localparam int SW = cnt_width(LS_STREAK);

   arb_state_t         r_state, w_state_next;
   logic               r_dram_req, w_dram_req_next;
   logic [DRAM_AW-1:0] r_dram_addr, w_dram_addr_next;
   logic [63:0]        r_dram_din, w_dram_din_next;
   logic [2:0]         r_dram_rd_ctrl, w_dram_rd_ctrl_next;
   logic [2:0]         r_dram_wr_ctrl, w_dram_wr_ctrl_next;
   logic               r_if_ack, w_if_ack_next;
   logic               r_ls_ack, w_ls_ack_next;
   logic [63:0]        r_if_rdata, w_if_rdata_next;
   logic [63:0]        r_ls_rdata, w_ls_rdata_next;
   logic               r_timeout_err, w_timeout_err_next;
   logic [SW-1:0]      r_streak, w_streak_next;

   logic w_tmo_load, w_tmo_clr, w_tmo_inc, w_tmo_expired;
   logic w_el_if, w_el_ls, w_ls_win, w_grant_if, w_grant_ls;

   arb_timeout_counter #(
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_tmo_load),
      .i_load_val ('0),
      .i_clr      (w_tmo_clr),
      .i_inc      (w_tmo_inc),
      .o_expired  (w_tmo_expired)
   );

   // A requester whose ack is showing this cycle still holds its request;
   // masking it prevents a duplicate grant of the request just served.
   assign w_el_if    = bus.if_req & ~r_if_ack;
   assign w_el_ls    = bus.ls_req & ~r_ls_ack;
   assign w_ls_win   = w_el_ls & ~(w_el_if & (r_streak == SW'(LS_STREAK)));
   assign w_grant_ls = (r_state == IDLE) & w_ls_win;
   assign w_grant_if = (r_state == IDLE) & w_el_if & ~w_ls_win;

   always_comb begin
      w_streak_next = r_streak;
      if (!bus.if_req || w_grant_if) begin
         w_streak_next = '0;
      end else if (w_grant_ls && (r_streak != SW'(LS_STREAK))) begin
         w_streak_next = r_streak + 1'b1;
      end
   end

   always_comb begin
      w_state_next        = r_state;
      w_dram_req_next     = r_dram_req;
      w_dram_addr_next    = r_dram_addr;
      w_dram_din_next     = r_dram_din;
      w_dram_rd_ctrl_next = r_dram_rd_ctrl;
      w_dram_wr_ctrl_next = r_dram_wr_ctrl;
      w_if_ack_next       = 1'b0;
      w_ls_ack_next       = 1'b0;
      w_if_rdata_next     = r_if_rdata;
      w_ls_rdata_next     = r_ls_rdata;
      w_timeout_err_next  = 1'b0;
      w_tmo_load          = 1'b0;
      w_tmo_clr           = 1'b0;
      w_tmo_inc           = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_grant_ls) begin
               w_state_next        = BUSY_LS;
               w_dram_req_next     = 1'b1;
               w_dram_addr_next    = bus.ls_addr;
               w_dram_din_next     = bus.ls_din;
               w_dram_wr_ctrl_next = bus.ls_wr_ctrl;
               // a combined read+write request is treated as a write
               w_dram_rd_ctrl_next = (bus.ls_wr_ctrl != 3'b000) ? 3'b000 : bus.ls_rd_ctrl;
               w_tmo_load          = 1'b1;
            end else if (w_grant_if) begin
               w_state_next        = BUSY_IF;
               w_dram_req_next     = 1'b1;
               w_dram_addr_next    = bus.if_addr;
               w_dram_rd_ctrl_next = IF_FETCH_CTRL;
               w_dram_wr_ctrl_next = 3'b000;
               w_tmo_load          = 1'b1;
            end
         end
         BUSY_IF, BUSY_LS: begin
            if (bus.dram_ack || w_tmo_expired) begin
               w_state_next        = IDLE;
               w_dram_req_next     = 1'b0;
               w_dram_rd_ctrl_next = 3'b000;
               w_dram_wr_ctrl_next = 3'b000;
               w_tmo_clr           = 1'b1;
               // a real ack on the last allowed cycle beats the abort
               w_timeout_err_next  = ~bus.dram_ack;
               if (r_state == BUSY_IF) begin
                  w_if_ack_next   = 1'b1;
                  w_if_rdata_next = bus.dram_ack ? bus.dram_rdata : 64'd0;
               end else begin
                  w_ls_ack_next   = 1'b1;
                  w_ls_rdata_next = (bus.dram_ack && (r_dram_wr_ctrl == 3'b000))
                                    ? bus.dram_rdata : 64'd0;
               end
            end else begin
               w_tmo_inc = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_dram_req     <= 1'b0;
         r_dram_addr    <= '0;
         r_dram_din     <= '0;
         r_dram_rd_ctrl <= '0;
         r_dram_wr_ctrl <= '0;
         r_if_ack       <= 1'b0;
         r_ls_ack       <= 1'b0;
         r_if_rdata     <= '0;
         r_ls_rdata     <= '0;
         r_timeout_err  <= 1'b0;
         r_streak       <= '0;
      end else begin
         r_state        <= w_state_next;
         r_dram_req     <= w_dram_req_next;
         r_dram_addr    <= w_dram_addr_next;
         r_dram_din     <= w_dram_din_next;
         r_dram_rd_ctrl <= w_dram_rd_ctrl_next;
         r_dram_wr_ctrl <= w_dram_wr_ctrl_next;
         r_if_ack       <= w_if_ack_next;
         r_ls_ack       <= w_ls_ack_next;
         r_if_rdata     <= w_if_rdata_next;
         r_ls_rdata     <= w_ls_rdata_next;
         r_timeout_err  <= w_timeout_err_next;
         r_streak       <= w_streak_next;
      end
   end

   assign bus.dram_req     = r_dram_req;
   assign bus.dram_addr    = r_dram_addr;
   assign bus.dram_din     = r_dram_din;
   assign bus.dram_rd_ctrl = r_dram_rd_ctrl;
   assign bus.dram_wr_ctrl = r_dram_wr_ctrl;
   assign bus.if_ack       = r_if_ack;
   assign bus.ls_ack       = r_ls_ack;
   assign bus.if_rdata     = r_if_rdata;
   assign bus.ls_rdata     = r_ls_rdata;
   assign bus.timeout_err  = r_timeout_err;
   assign bus.stall_if     = bus.if_req & ~r_if_ack;
   assign bus.stall_ls     = bus.ls_req & ~r_ls_ack;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_port_arbiter
//   Directed scenarios followed by randomized requester/DRAM traffic. A
//   transaction-level reference (current owner, wait count, streak) predicts
//   every registered output each cycle.
// ---------------------------------------------------------------------------
module tb_dram_port_arbiter;

   localparam int TMO = 8;
   localparam int LSS = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dram_port_arbiter_if #(.DRAM_AW(64)) bus ();

   dram_port_arbiter #(
      .TIMEOUT   (TMO),
      .LS_STREAK (LSS),
      .DRAM_AW   (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference state
   int          m_owner;   // 0 none, 1 IF, 2 LS
   int          m_wait, m_lat, m_streak;
   bit          m_req, m_if_ack, m_ls_ack, m_terr, m_rst;
   logic [63:0] m_addr, m_din, m_if_rdata, m_ls_rdata;
   logic [2:0]  m_rd, m_wr;

   int          forced_lat = -1;
   bit          use_forced = 0;
   bit          spurious   = 0;
   logic [63:0] forced_rdata = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick_lat();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return $urandom_range(0, 3);
      if (r < 9) return $urandom_range(4, TMO);
      return $urandom_range(TMO + 1, TMO + 7);
   endfunction

   task automatic finish_xact(input bit aborted);
      logic [63:0] data;
      data = (aborted || (m_owner == 2 && m_wr != 3'b000)) ? 64'd0 : bus.dram_rdata;
      if (m_owner == 1) begin m_if_ack = 1; m_if_rdata = data; end
      else              begin m_ls_ack = 1; m_ls_rdata = data; end
      $display("txn %s addr=%h rd=%0d wr=%0d rdata=%h timeout=%0d",
               (m_owner == 1) ? "IF" : "LS", m_addr, m_rd, m_wr, data, aborted);
      m_terr  = aborted;
      m_req   = 0;
      m_rd    = 0;
      m_wr    = 0;
      m_owner = 0;
   endtask

   // reference transition for one rising edge, using the inputs now applied
   task automatic model_edge();
      bit el_if, el_ls;
      int win;
      if (!reset) begin
         m_owner = 0; m_wait = 0; m_streak = 0; m_req = 0; m_if_ack = 0; m_ls_ack = 0;
         m_terr = 0; m_addr = 0; m_din = 0; m_if_rdata = 0; m_ls_rdata = 0;
         m_rd = 0; m_wr = 0; m_rst = 1;
         return;
      end
      m_rst = 0;
      el_if = bus.if_req && !m_if_ack;
      el_ls = bus.ls_req && !m_ls_ack;
      m_if_ack = 0; m_ls_ack = 0; m_terr = 0;
      win = 0;
      if (m_owner == 0) begin
         if (el_ls && !(el_if && m_streak == LSS)) win = 2;
         else if (el_if) win = 1;
         if (win != 0) begin
            m_owner = win; m_req = 1; m_wait = 0;
            m_lat = (forced_lat >= 0) ? forced_lat : pick_lat();
            if (win == 2) begin
               m_addr = bus.ls_addr; m_din = bus.ls_din; m_wr = bus.ls_wr_ctrl;
               m_rd = (bus.ls_wr_ctrl != 0) ? 3'd0 : bus.ls_rd_ctrl;
            end else begin
               m_addr = bus.if_addr; m_rd = 3'b011; m_wr = 0;
            end
         end
      end else if (bus.dram_ack) begin
         finish_xact(0);
      end else if (m_wait == TMO) begin
         finish_xact(1);
      end else begin
         m_wait++;
      end
      if (!bus.if_req || win == 1) m_streak = 0;
      else if (win == 2 && m_streak < LSS) m_streak++;
   endtask

   task automatic compare_outputs();
      chk("dram_req", bus.dram_req, m_req);
      chk("dram_rd_ctrl", bus.dram_rd_ctrl, m_rd);
      chk("dram_wr_ctrl", bus.dram_wr_ctrl, m_wr);
      if (m_req || m_rst) chk("dram_addr", bus.dram_addr, m_addr);
      if ((m_req && m_owner == 2) || m_rst) chk("dram_din", bus.dram_din, m_din);
      chk("if_ack", bus.if_ack, m_if_ack);
      chk("ls_ack", bus.ls_ack, m_ls_ack);
      chk("timeout_err", bus.timeout_err, m_terr);
      chk("if_rdata", bus.if_rdata, m_if_rdata);
      chk("ls_rdata", bus.ls_rdata, m_ls_rdata);
   endtask

   task automatic drive_dram();
      bus.dram_rdata = use_forced ? forced_rdata : {$urandom, $urandom};
      if (m_owner != 0) bus.dram_ack = (m_wait == m_lat);
      else              bus.dram_ack = spurious && ($urandom_range(0, 7) == 0);
   endtask

   task automatic step();
      #1;
      chk("stall_if", bus.stall_if, bus.if_req & ~m_if_ack);
      chk("stall_ls", bus.stall_ls, bus.ls_req & ~m_ls_ack);
      model_edge();
      @(posedge clk);
      #1;
      compare_outputs();
      drive_dram();
   endtask

   // one directed transaction; returns cycles from request to observed ack
   task automatic do_xact(input bit is_ls, input logic [63:0] addr, input logic [63:0] din,
                          input logic [2:0] rd, input logic [2:0] wr, input int lat,
                          input logic [63:0] rdata, output int cyc,
                          output logic [2:0] g_rd, output logic [2:0] g_wr,
                          output logic [63:0] g_din);
      bit done;
      forced_lat = lat; forced_rdata = rdata; use_forced = 1;
      if (is_ls) begin
         bus.ls_req = 1; bus.ls_addr = addr; bus.ls_din = din;
         bus.ls_rd_ctrl = rd; bus.ls_wr_ctrl = wr;
      end else begin
         bus.if_req = 1; bus.if_addr = addr;
      end
      cyc = 0; done = 0; g_rd = 0; g_wr = 0; g_din = 0;
      while (!done && cyc < 40) begin
         step();
         cyc++;
         if (cyc == 1) begin g_rd = bus.dram_rd_ctrl; g_wr = bus.dram_wr_ctrl; g_din = bus.dram_din; end
         done = is_ls ? bus.ls_ack : bus.if_ack;
      end
      if (!done) chk("xact_bound", 64'd0, 64'd1);
      if (is_ls) bus.ls_req = 0; else bus.if_req = 0;
      use_forced = 0; forced_lat = -1;
   endtask

   initial begin
      int cyc, lsc, ifc, first;
      logic [2:0]  g_rd, g_wr;
      logic [63:0] g_din;

      reset = 0;
      bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_addr = 0; bus.ls_din = 0;
      bus.ls_rd_ctrl = 0; bus.ls_wr_ctrl = 0; bus.dram_ack = 0; bus.dram_rdata = 0;

      repeat (3) step();
      chk("rst_dram_req", bus.dram_req, 0);
      chk("rst_dram_addr", bus.dram_addr, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      reset = 1;
      step();

      // single IF read, dram_ack in the third busy cycle
      do_xact(0, 64'h8000_0000, 0, 0, 0, 2, 64'h1122334455667788, cyc, g_rd, g_wr, g_din);
      chk("if_latency", cyc, 4);
      chk("if_grant_rd", g_rd, 3'b011);
      chk("if_rdata_val", bus.if_rdata, 64'h1122334455667788);
      step();
      chk("if_ack_pulse_end", bus.if_ack, 0);
      chk("stall_if_low", bus.stall_if, 0);

      // LS store, immediate dram_ack
      do_xact(1, 64'h8000_0010, 64'hDEAD_BEEF, 0, 3'b011, 0, 64'hFFFF_0000_FFFF_0000,
              cyc, g_rd, g_wr, g_din);
      chk("st_latency", cyc, 2);
      chk("st_wr_ctrl", g_wr, 3'b011);
      chk("st_rd_ctrl", g_rd, 3'b000);
      chk("st_din", g_din, 64'hDEAD_BEEF);
      chk("st_rdata", bus.ls_rdata, 0);
      step();

      // simultaneous requests: LS first, IF granted at the ls_ack edge
      forced_lat = 0; use_forced = 1; forced_rdata = 64'h0123_4567_89AB_CDEF;
      bus.if_req = 1; bus.if_addr = 64'h100; bus.ls_req = 1; bus.ls_addr = 64'h200;
      bus.ls_rd_ctrl = 3'b010; bus.ls_wr_ctrl = 0;
      lsc = -1; ifc = -1; first = 0;
      for (int c = 1; c <= 20 && (lsc < 0 || ifc < 0); c++) begin
         step();
         if (bus.ls_ack) begin lsc = c; bus.ls_req = 0; if (first == 0) first = 2; end
         if (bus.if_ack) begin ifc = c; bus.if_req = 0; if (first == 0) first = 1; end
      end
      chk("sim_first_owner", first, 2);
      chk("sim_ls_latency", lsc, 2);
      chk("sim_if_gap", ifc - lsc, 2);
      use_forced = 0; forced_lat = -1;
      step();

      // timeout abort: no dram_ack at all
      do_xact(1, 64'h300, 0, 3'b010, 0, 100, 64'h5555, cyc, g_rd, g_wr, g_din);
      chk("tmo_latency", cyc, TMO + 2);
      chk("tmo_err", bus.timeout_err, 1);
      chk("tmo_ls_ack", bus.ls_ack, 1);
      chk("tmo_rdata", bus.ls_rdata, 0);
      chk("tmo_dram_req", bus.dram_req, 0);
      step();
      chk("tmo_err_pulse_end", bus.timeout_err, 0);

      // dram_ack on the last allowed busy cycle completes normally
      do_xact(1, 64'h308, 0, 3'b011, 0, TMO, 64'hCAFE_F00D_1234_5678, cyc, g_rd, g_wr, g_din);
      chk("edge_latency", cyc, TMO + 2);
      chk("edge_no_err", bus.timeout_err, 0);
      chk("edge_rdata", bus.ls_rdata, 64'hCAFE_F00D_1234_5678);
      step();

      // reset during BUSY_IF abandons the transaction
      forced_lat = 100;
      bus.if_req = 1; bus.if_addr = 64'h400;
      repeat (3) step();
      chk("busy_before_rst", bus.dram_req, 1);
      reset = 0;
      step();
      chk("rst2_dram_req", bus.dram_req, 0);
      chk("rst2_rd_ctrl", bus.dram_rd_ctrl, 0);
      chk("rst2_if_ack", bus.if_ack, 0);
      bus.if_req = 0; forced_lat = -1;
      reset = 1;
      repeat (3) step();
      chk("rst2_no_late_ack", bus.if_ack, 0);
      do_xact(0, 64'h408, 0, 0, 0, 1, 64'hABCD, cyc, g_rd, g_wr, g_din);
      chk("post_rst_latency", cyc, 3);
      chk("post_rst_rdata", bus.if_rdata, 64'hABCD);
      step();

      // read and write both requested: write wins
      do_xact(1, 64'h500, 64'h77, 3'b010, 3'b010, 1, 64'h9999, cyc, g_rd, g_wr, g_din);
      chk("rw_wr_ctrl", g_wr, 3'b010);
      chk("rw_rd_ctrl", g_rd, 3'b000);
      chk("rw_rdata", bus.ls_rdata, 0);
      step();

      // randomized traffic
      spurious = 1;
      for (int n = 0; n < 3000; n++) begin
         step();
         reset = ($urandom_range(0, 299) != 0);
         if (m_if_ack) begin
            bus.if_req = $urandom_range(0, 1);
            bus.if_addr = {$urandom, $urandom};
         end else if (!bus.if_req) begin
            if (m_owner != 1 && $urandom_range(0, 2) == 0) begin
               bus.if_req = 1; bus.if_addr = {$urandom, $urandom};
            end
         end else if (m_owner == 1 && $urandom_range(0, 19) == 0) begin
            bus.if_req = 0;
         end
         if (m_ls_ack || (!bus.ls_req && m_owner != 2 && $urandom_range(0, 2) == 0)) begin
            bus.ls_req = m_ls_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ls_addr = {$urandom, $urandom};
            bus.ls_din = {$urandom, $urandom};
            bus.ls_rd_ctrl = 3'($urandom_range(0, 7));
            bus.ls_wr_ctrl = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
         end else if (bus.ls_req && m_owner == 2 && $urandom_range(0, 19) == 0) begin
            bus.ls_req = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
